// File: rtl/layer_stream_pkg.sv
// Shared state encoding and width defaults for the layer stream driver.
package layer_stream_pkg;

    localparam int unsigned LAYER_T = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Index counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_drv_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to throttle rx_ready.
module stream_drv_lfsr (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 8'hA5;
        end else begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/layer_stream_driver.sv
// Streams an N-element vector into one FC layer and gathers its M outputs.
// Define LAYER_STREAM_DRIVER_BACKPRESSURE_EN to throttle rx_ready with an LFSR.
module layer_stream_driver
    import layer_stream_pkg::*;
#(
    parameter int unsigned T = LAYER_T,
    parameter int unsigned N = 12,
    parameter int unsigned M = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*T-1:0] vec_in,
    output logic           busy,
    output logic           done,
    output logic [M*T-1:0] result_out,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [T-1:0]   tx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    input  logic [T-1:0]   rx_data
);

    localparam int unsigned TXW = idx_width(N);
    localparam int unsigned RXW = idx_width(M);
    localparam logic [TXW-1:0] TX_LAST = TXW'(N - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(M - 1);

    state_e         state_q;
    logic [N*T-1:0] vbuf_q;
    logic [TXW-1:0] tx_idx_q;
    logic [TXW-1:0] tx_idx_d;
    logic [RXW-1:0] rx_idx_q;
    logic [RXW-1:0] rx_idx_d;
    logic [M*T-1:0] result_q;
    logic [T-1:0]   tx_data_q;
    logic           tx_valid_q;
    logic           busy_q;
    logic           done_q;
    logic           in_recv;
    logic           tx_fire;
    logic           rx_fire;

    assign tx_idx_d = tx_idx_q + TXW'(1);
    assign rx_idx_d = rx_idx_q + RXW'(1);
    assign in_recv  = (state_q == RECV);
    assign tx_fire  = tx_valid_q && tx_ready;
    assign rx_fire  = rx_valid && rx_ready;

`ifdef LAYER_STREAM_DRIVER_BACKPRESSURE_EN
    logic [7:0] lfsr_q;

    stream_drv_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign rx_ready = in_recv && lfsr_q[0];
`else
    assign rx_ready = in_recv;
`endif

    // Sequencer: capture, stream out, collect, then hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            vbuf_q     <= '0;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vbuf_q     <= vec_in;
                        tx_idx_q   <= '0;
                        tx_data_q  <= vec_in[T-1:0];
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (tx_idx_q == TX_LAST) begin
                            tx_valid_q <= 1'b0;
                            rx_idx_q   <= '0;
                            state_q    <= RECV;
                        end else begin
                            tx_idx_q  <= tx_idx_d;
                            tx_data_q <= vbuf_q[tx_idx_d*T +: T];
                        end
                    end
                end
                RECV: begin
                    if (rx_fire) begin
                        result_q[rx_idx_q*T +: T] <= rx_data;
                        if (rx_idx_q == RX_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rx_idx_q <= rx_idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result_out = result_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_layer_stream_driver.sv
// Self-checking bench for layer_stream_driver with a behavioural layer model.
module tb_layer_stream_driver;

    localparam int T = 20;
    localparam int N = 12;
    localparam int M = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N*T-1:0] vec_in = '0;
    logic           busy;
    logic           done;
    logic [M*T-1:0] result_out;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic [T-1:0]   tx_data;
    logic           rx_valid = 1'b0;
    logic           rx_ready;
    logic [T-1:0]   rx_data = '0;

    layer_stream_driver #(.T(T), .N(N), .M(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vec_in     (vec_in),
        .busy       (busy),
        .done       (done),
        .result_out (result_out),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Layer model state and knobs
    logic [T-1:0] out_vals [M];
    logic [T-1:0] tx_seen [$];
    int           lm_phase = 0;
    int           lm_tx = 0;
    int           lm_j = 0;
    int           lm_wait = 0;
    int           rsp_delay = 3;
    bit           rnd_mode = 1'b0;
    int           stall_at = -1;
    int           stall_len = 0;
    int           stall_cnt = 0;
    int           hold_cnt = 0;
    int           nrdy_cnt = 0;
    bit           rx_hold = 1'b0;
    bit           tx_prev_hold = 1'b0;
    logic [T-1:0] tx_prev_data = '0;

    // Drive the layer side at negedge, then observe what the next posedge will see.
    always @(negedge clk) begin
        tx_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (lm_tx == stall_at && stall_cnt < stall_len) begin
            tx_ready = 1'b0;
            stall_cnt++;
        end
        if (lm_phase == 1) begin
            if (lm_wait == 0) lm_phase = 2;
            else lm_wait--;
        end
        if (lm_phase == 2) begin
            if (!rx_hold) rx_valid = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            rx_data = out_vals[lm_j];
        end else begin
            rx_valid = 1'b0;
        end
        #1;
        if (reset) begin
            lm_phase = 0; lm_tx = 0; lm_j = 0;
            rx_hold = 1'b0; tx_prev_hold = 1'b0;
        end else begin
            if (tx_prev_hold) begin
                hold_cnt++;
                check("tx_hold_valid", 64'(tx_valid), 64'(1));
                check("tx_hold_data", 64'(tx_data), 64'(tx_prev_data));
            end
            tx_prev_hold = tx_valid && !tx_ready;
            tx_prev_data = tx_data;
            if (tx_valid && tx_ready) begin
                tx_seen.push_back(tx_data);
                lm_tx++;
                if (lm_tx == N) begin
                    lm_phase = 1;
                    lm_wait  = rsp_delay;
                end
            end
            if (rx_valid && !rx_ready) nrdy_cnt++;
            rx_hold = rx_valid && !rx_ready;
            if (rx_valid && rx_ready) begin
                lm_j++;
                if (lm_j == M) begin
                    lm_phase = 0; lm_tx = 0; lm_j = 0;
                end
            end
        end
    end

    function automatic logic [N*T-1:0] rand_vec();
        logic [N*T-1:0] v;
        for (int k = 0; k < N; k++) v[k*T +: T] = T'($urandom);
        return v;
    endfunction

    task automatic rand_outs();
        for (int j = 0; j < M; j++) out_vals[j] = T'($urandom);
    endtask

    // Called at a negedge with the DUT idle or done.
    task automatic begin_run(input logic [N*T-1:0] v);
        tx_seen.delete();
        stall_cnt = 0;
        hold_cnt  = 0;
        start  = 1'b1;
        vec_in = v;
        @(negedge clk);
        start  = 1'b0;
        vec_in = rand_vec();
        check("lat_tx_valid", 64'(tx_valid), 64'(1));
        check("lat_tx_data", 64'(tx_data), 64'(v[T-1:0]));
        check("lat_busy", 64'(busy), 64'(1));
        check("lat_rx_ready", 64'(rx_ready), 64'(0));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic wait_model(input string tag, input int tx_min, input int rx_min);
        for (int i = 0; i < 3000 && !(lm_tx >= tx_min && lm_j >= rx_min); i++) @(negedge clk);
        check(tag, 64'(lm_tx >= tx_min && lm_j >= rx_min), 64'(1));
    endtask

    task automatic check_results(input string tag, input logic [N*T-1:0] v);
        check({tag, "_tx_count"}, 64'(tx_seen.size()), 64'(N));
        for (int k = 0; k < N && k < tx_seen.size(); k++)
            check($sformatf("%s_tx%0d", tag, k), 64'(tx_seen[k]), 64'(v[k*T +: T]));
        for (int j = 0; j < M; j++)
            check($sformatf("%s_res%0d", tag, j), 64'(result_out[j*T +: T]), 64'(out_vals[j]));
    endtask

    task automatic check_done_width(input string tag);
        @(negedge clk);
        check({tag, "_done_width"}, 64'(done), 64'(0));
        check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    logic [N*T-1:0] v_dir;
    logic [N*T-1:0] va;
    logic [N*T-1:0] vb;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_tx_valid", 64'(tx_valid), 64'(0));
            check("rst_rx_ready", 64'(rx_ready), 64'(0));
            check("rst_result", 64'(|result_out), 64'(0));
        end

        // Directed: element k carries k+1, layer returns j*10
        for (int k = 0; k < N; k++) v_dir[k*T +: T] = T'(k + 1);
        for (int j = 0; j < M; j++) out_vals[j] = T'(j * 10);
        rsp_delay = 3;
        nrdy_cnt  = 0;
        begin_run(v_dir);
        wait_done("dir");
        check_results("dir", v_dir);
        check("dir_res5", 64'(result_out[5*T +: T]), 64'(50));
        check("dir_res15", 64'(result_out[15*T +: T]), 64'(150));
        check_done_width("dir");
`ifdef LAYER_STREAM_DRIVER_BACKPRESSURE_EN
        check("bp_hold_seen", 64'(nrdy_cnt > 0), 64'(1));
`else
        check("no_bp_stall", 64'(nrdy_cnt), 64'(0));
`endif

        // tx_ready low for 4 cycles while element 3 is presented
        stall_at  = 3;
        stall_len = 4;
        begin_run(v_dir);
        wait_done("stall");
        check_results("stall", v_dir);
        check("stall_hold_cycles", 64'(hold_cnt), 64'(4));
        check_done_width("stall");
        stall_at = -1;

        // Negative data passes through unmodified
        rand_outs();
        out_vals[0] = T'(-497);
        va = rand_vec();
        begin_run(va);
        wait_done("neg");
        check_results("neg", va);
        check("neg_res0", 64'(result_out[19:0]), 64'(20'hFFE0F));
        check_done_width("neg");

        // start during SEND is ignored; start in the done cycle is accepted
        rand_outs();
        va = rand_vec();
        vb = rand_vec();
        begin_run(va);
        wait_model("mid_wait", 5, 0);
        start  = 1'b1;
        vec_in = vb;
        @(negedge clk);
        start  = 1'b0;
        vec_in = rand_vec();
        wait_done("mid");
        check_results("mid", va);
        rand_outs();
        begin_run(vb);
        wait_done("chain");
        check_results("chain", vb);
        check_done_width("chain");

        // Reset in RECV after 7 outputs aborts and clears the result
        rand_outs();
        va = rand_vec();
        begin_run(va);
        wait_model("abort_wait", N, 7);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_tx_valid", 64'(tx_valid), 64'(0));
        check("abort_tx_data", 64'(tx_data), 64'(0));
        check("abort_rx_ready", 64'(rx_ready), 64'(0));
        check("abort_result", 64'(|result_out), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        rand_outs();
        va = rand_vec();
        begin_run(va);
        wait_done("post_abort");
        check_results("post_abort", va);
        check_done_width("post_abort");

        // Randomised handshakes on both sides
        rnd_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            rand_outs();
            va = rand_vec();
            rsp_delay = $urandom_range(0, 6);
            begin_run(va);
            wait_done("rnd");
            check_results("rnd", va);
            check_done_width("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/layer_stream_driver.md
Name: layer_stream_driver

Overview:
- Initiator for one fully-connected layer instance that uses the s_valid/s_ready input and m_valid/m_ready output handshake.
- Captures an N-element input vector in parallel, streams it element by element into the layer, then collects the M neuron outputs the layer streams back.
- Presents the M outputs as a parallel result vector with a done pulse.
- Sits between the network-level sequencer/testbench and each layer.

Parameters:
T, 20, data width in bits (signed two's complement).
N, 12, number of input elements sent per vector.
M, 16, number of output elements collected per vector.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  request to process vec_in; sampled only in IDLE or DONE
vec_in  input  N*T  input vector; element k = vec_in[k*T +: T]
busy  output  1  high in SEND and RECV
done  output  1  one-cycle pulse when the last output is stored
result_out  output  M*T  collected outputs; element j = result_out[j*T +: T]
tx_valid  output  1  to layer s_valid
tx_ready  input  1  from layer s_ready
tx_data  output  T  to layer data_in
rx_valid  input  1  from layer m_valid
rx_ready  output  1  to layer m_ready
rx_data  input  T  from layer data_out

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, tx_valid=0, tx_data=0, rx_ready=0.
  - result_out=0; tx_idx=0, rx_idx=0.
  - Reset asserted mid-operation aborts immediately. The result is cleared. No partial done.
- States: IDLE, SEND, RECV, DONE.
- IDLE/DONE:
  - On start=1, register vec_in into vbuf and set tx_idx=0.
  - Next cycle: state=SEND, tx_valid=1, tx_data=vbuf[0].
  - done is 1 only in the first cycle after entering DONE.
  - result_out holds its value in DONE and IDLE until the next start.
- SEND:
  - tx_valid and tx_data are registered.
  - A transfer occurs on a cycle where tx_valid && tx_ready.
  - On a transfer with tx_idx<N-1: tx_idx++, and tx_data=vbuf[tx_idx+1] next cycle. tx_valid stays 1.
  - On a transfer with tx_idx==N-1: tx_valid=0 next cycle, state=RECV, rx_idx=0.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- RECV:
  - rx_ready=1 combinationally whenever state==RECV (subject to the optional feature).
  - A transfer occurs on a cycle where rx_valid && rx_ready: result[rx_idx] <= rx_data, then rx_idx++.
  - After the transfer with rx_idx==M-1: state=DONE.
  - rx_ready=0 in all other states, so a layer output that arrives early is held by the layer.
- start while busy=1 is ignored; vec_in changes during busy have no effect.
- start in the same cycle as done (state DONE) is accepted.
- Latency:
  - start to first tx_valid: 1 cycle.
  - Best case with tx_ready=1: N cycles of SEND, then RECV.
  - Cycle count in RECV depends on the layer's MAC latency (about N+2 cycles per output).
- No arithmetic. Data passes through unmodified at width T.
- Counter widths are $clog2(N) and $clog2(M), with no wrap beyond N-1 or M-1.

Optional Feature:
- Macro: LAYER_STREAM_DRIVER_BACKPRESSURE_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded 8'hA5 on reset and advances every cycle.
  - In RECV, rx_ready = lfsr[0].
  - Purpose: stress-test the layer's m_valid hold.
- When undefined:
  - No LFSR is instantiated.
  - rx_ready = (state==RECV).
- Functional results must be identical either way; only timing differs.

Decomposition:
- Package layer_stream_pkg:
  - state enum (IDLE, SEND, RECV, DONE) as a 2-bit typedef.
  - default width constant LAYER_T=20.
- One sub-module is natural: stream_drv_lfsr (clk, reset, q[7:0]). It is instantiated only under the macro.
- Main FSM and buffers stay in layer_stream_driver.

Test Plan:
- Reset, then idle 5 cycles: busy=0, done=0, tx_valid=0, rx_ready=0, result_out=0.
- Behavioural layer model with tx_ready=1 and rx_valid asserted 3 cycles after SEND ends. vec_in elements k=1..12 (value k+1 at index k); model returns j*10 for j=0..15. Required:
  - 12 tx transfers carrying 1..12 in order.
  - result_out element 5 = 50, element 15 = 150.
  - done high for exactly 1 cycle.
- tx_ready deasserted for 4 cycles at element 3 (value 4): tx_data stays 4 and tx_valid stays 1 throughout; no element is duplicated or skipped.
- Negative data: the model returns -20'd497 for j=0: result_out[19:0] = 20'hFFE0F.
- start pulsed during SEND with a different vec_in: ignored; the original vector completes. A second start in the done cycle begins a new SEND the next cycle.
- reset asserted at RECV element 7: next cycle is IDLE with result_out=0. A subsequent full run produces correct results.
- With LAYER_STREAM_DRIVER_BACKPRESSURE_EN defined, rerun the second scenario: result_out must be identical, and at least one RECV cycle must have rx_valid=1 with rx_ready=0.
